// File: rtl/fb_arbiter.sv
// Framebuffer arbiter: shares one single-port, synchronous-read pixel RAM
// between LCD scan-out and a host read/write port, keeping lcd_pixels coherent.
module fb_arbiter #(
    parameter int WIDTH     = 240,
    parameter int PAGES     = 8,
    parameter int ADDR_BITS = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           lcd_x,
    input  logic [3:0]           lcd_y,
    output logic [7:0]           lcd_pixels,
    input  logic                 wr_valid,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [7:0]           wr_data,
    output logic                 wr_ready,
    input  logic                 rd_valid,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic                 rd_ready,
    output logic [7:0]           rd_data,
    output logic                 rd_data_valid,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic [7:0]           ram_wdata,
    output logic                 ram_we,
    input  logic [7:0]           ram_rdata
);

    localparam logic [ADDR_BITS-1:0] FB_END = ADDR_BITS'(WIDTH * PAGES);
    localparam logic [7:0]           X_END  = 8'(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LCD_RD,
        S_LCD_CAP,
        S_HOST_WR,
        S_HOST_RD,
        S_HOST_CAP
    } state_t;

    state_t                 state, state_nx;
    logic [ADDR_BITS-1:0]   page_w;
    logic [ADDR_BITS-1:0]   x_w;
    logic [ADDR_BITS-1:0]   lcd_addr;
    logic                   lcd_oob;
    logic                   wr_in_range;
    logic                   rd_in_range;
    logic                   lcd_dirty;
    logic                   dirty_q;
    logic [ADDR_BITS-1:0]   fetched_addr;
    logic                   fetched_oob;
    logic                   last_lcd;
    logic                   rd_oob;
    logic                   unused_y3;

    assign unused_y3 = lcd_y[3];

    // page*WIDTH folded into shifts: page*240 = page*256 - page*16
    assign page_w   = ADDR_BITS'(lcd_y[2:0]);
    assign x_w      = ADDR_BITS'(lcd_x);
    assign lcd_addr = (page_w << 8) - (page_w << 4) + x_w;
    assign lcd_oob  = (lcd_x >= X_END);

    assign wr_in_range = (wr_addr < FB_END);
    assign rd_in_range = (rd_addr < FB_END);

    // A fetch is owed when the coordinate moved or the shown byte was overwritten
    assign lcd_dirty = dirty_q || (lcd_addr != fetched_addr) || (lcd_oob != fetched_oob);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (lcd_dirty && !last_lcd) state_nx = S_LCD_RD;
                else if (wr_valid)          state_nx = S_HOST_WR;
                else if (rd_valid)          state_nx = S_HOST_RD;
                else if (lcd_dirty)         state_nx = S_LCD_RD;
                else                        state_nx = S_IDLE;
            end
            S_LCD_RD:  state_nx = S_LCD_CAP;
            S_HOST_RD: state_nx = S_HOST_CAP;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            lcd_pixels    <= 8'h00;
            rd_data       <= 8'h00;
            ram_addr      <= '0;
            ram_wdata     <= 8'h00;
            ram_we        <= 1'b0;
            wr_ready      <= 1'b0;
            rd_ready      <= 1'b0;
            rd_data_valid <= 1'b0;
            fetched_addr  <= '0;
            fetched_oob   <= 1'b0;
            dirty_q       <= 1'b1;
            last_lcd      <= 1'b0;
            rd_oob        <= 1'b0;
        end else begin
            state         <= state_nx;
            wr_ready      <= (state_nx == S_HOST_WR);
            ram_we        <= (state_nx == S_HOST_WR) && wr_in_range;
            rd_ready      <= (state == S_HOST_RD);
            rd_data_valid <= (state == S_HOST_CAP);

            if (state == S_IDLE) begin
                case (state_nx)
                    S_LCD_RD: begin
                        fetched_addr <= lcd_addr;
                        fetched_oob  <= lcd_oob;
                        dirty_q      <= 1'b0;
                        last_lcd     <= 1'b1;
                        if (!lcd_oob) ram_addr <= lcd_addr;
                    end
                    S_HOST_WR: begin
                        last_lcd  <= 1'b0;
                        ram_wdata <= wr_data;
                        if (wr_in_range) ram_addr <= wr_addr;
                    end
                    S_HOST_RD: begin
                        last_lcd <= 1'b0;
                        rd_oob   <= !rd_in_range;
                        if (rd_in_range) ram_addr <= rd_addr;
                    end
                    default: ;
                endcase
            end

            // Overwriting the displayed byte forces a re-fetch on the next LCD grant
            if (state == S_HOST_WR && ram_we && ram_addr == fetched_addr && !fetched_oob)
                dirty_q <= 1'b1;

            if (state == S_LCD_CAP)
                lcd_pixels <= fetched_oob ? 8'h00 : ram_rdata;

            if (state == S_HOST_CAP)
                rd_data <= rd_oob ? 8'h00 : ram_rdata;
        end
    end

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a behavioural synchronous-read RAM.
module tb_fb_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  lcd_x = 8'd0;
    logic [3:0]  lcd_y = 4'd0;
    logic [7:0]  lcd_pixels;
    logic        wr_valid = 1'b0;
    logic [10:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        wr_ready;
    logic        rd_valid = 1'b0;
    logic [10:0] rd_addr = '0;
    logic        rd_ready;
    logic [7:0]  rd_data;
    logic        rd_data_valid;
    logic [10:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [7:0]  ram_rdata = 8'h00;

    int total = 0;
    int bad   = 0;

    logic [7:0] wmem    [0:2047];
    logic       written [0:2047];

    always #5 clk = ~clk;

    fb_arbiter dut (
        .clk(clk), .reset(reset),
        .lcd_x(lcd_x), .lcd_y(lcd_y), .lcd_pixels(lcd_pixels),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
    );

    function automatic logic [7:0] init_val(input logic [10:0] a);
        if (a == 11'd0)    return 8'hA5;
        if (a == 11'd250)  return 8'h11;
        if (a == 11'd2000) return 8'hEE;
        return a[7:0];
    endfunction

    function automatic logic [7:0] model(input logic [10:0] a);
        return written[a] ? wmem[a] : init_val(a);
    endfunction

    always @(posedge clk) begin
        if (ram_we) begin
            wmem[ram_addr]    <= ram_wdata;
            written[ram_addr] <= 1'b1;
        end
        ram_rdata <= model(ram_addr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [10:0] a, input logic [7:0] d,
                              input logic exp_we, input string tag);
        bit seen = 0;
        wr_addr  = a;
        wr_data  = d;
        wr_valid = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (wr_ready) seen = 1;
        end
        check({tag, "_ack"}, 32'(seen), 1);
        check({tag, "_we"}, 32'(ram_we), 32'(exp_we));
        if (exp_we) begin
            check({tag, "_addr"}, 32'(ram_addr), 32'(a));
            check({tag, "_wdata"}, 32'(ram_wdata), 32'(d));
        end
        wr_valid = 1'b0;
        tick();
        check({tag, "_pulse"}, {30'd0, wr_ready, ram_we}, 0);
    endtask

    task automatic host_read(input logic [10:0] a, input logic [7:0] exp, input string tag);
        bit seen = 0;
        rd_addr  = a;
        rd_valid = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (rd_ready) seen = 1;
        end
        check({tag, "_ack"}, 32'(seen), 1);
        check({tag, "_dv_early"}, 32'(rd_data_valid), 0);
        rd_valid = 1'b0;
        tick();
        check({tag, "_dv"}, {30'd0, rd_ready, rd_data_valid}, 1);
        check({tag, "_data"}, 32'(rd_data), 32'(exp));
        tick();
        check({tag, "_dv_pulse"}, 32'(rd_data_valid), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int gap, maxgap, npulse;
        logic [10:0] held_addr;

        // Reset held: every handshake and data output stays low
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_hs", {28'd0, wr_ready, rd_ready, rd_data_valid, ram_we}, 0);
            check("rst_pix", 32'(lcd_pixels), 0);
        end
        check("rst_addr", 32'(ram_addr), 0);
        reset = 1'b1;
        tick();
        check("init_fetch_addr", 32'(ram_addr), 0);
        check("init_fetch_we", 32'(ram_we), 0);
        tick();
        check("init_pix_early", 32'(lcd_pixels), 0);
        tick();
        check("init_pix", 32'(lcd_pixels), 32'h A5);

        // Top address write then read back
        host_write(11'd1919, 8'h3C, 1'b1, "wr1919");
        host_read(11'd1919, 8'h3C, "rd1919");

        // Last column of page 7, then an out-of-range column
        lcd_x = 8'd239;
        lcd_y = 4'b0111;
        tick();
        check("p7_addr", 32'(ram_addr), 1919);
        tick();
        tick();
        check("p7_pix", 32'(lcd_pixels), 32'h3C);
        lcd_x = 8'd240;
        held_addr = ram_addr;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("oob_no_read", 32'(ram_addr), 32'(held_addr));
        end
        check("oob_pix", 32'(lcd_pixels), 0);

        // Host overwrites the displayed byte
        lcd_x = 8'd10;
        lcd_y = 4'd1;
        for (int i = 0; i < 4; i++) tick();
        check("a250_pix", 32'(lcd_pixels), 32'h11);
        host_write(11'd250, 8'h77, 1'b1, "wr250");
        tick();
        check("refetch_addr", 32'(ram_addr), 250);
        tick();
        tick();
        check("refetch_pix", 32'(lcd_pixels), 32'h77);

        // Continuous writes against a moving LCD coordinate
        lcd_y    = 4'd0;
        wr_addr  = 11'd1000;
        wr_data  = 8'h40;
        wr_valid = 1'b1;
        gap = 0; maxgap = 0; npulse = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            lcd_x = (lcd_x == 8'd239) ? 8'd0 : lcd_x + 8'd1;
            if (wr_ready) begin
                if (npulse > 0 && gap > maxgap) maxgap = gap;
                gap = 0;
                npulse++;
                wr_addr = wr_addr + 11'd1;
                wr_data = wr_data + 8'd1;
            end else begin
                gap++;
            end
        end
        wr_valid = 1'b0;
        check("alt_max_gap", 32'(maxgap), 4);
        check("alt_pulses", 32'(npulse >= 9), 1);
        for (int i = 0; i < 6; i++) tick();
        check("alt_pix", 32'(lcd_pixels), 32'(model(11'(lcd_x))));
        host_read(11'd1000, 8'h40, "rd1000");
        host_read(11'd1003, 8'h43, "rd1003");

        // Out-of-range host accesses
        host_write(11'd2000, 8'h12, 1'b0, "wr2000");
        check("wr2000_mem", 32'(model(11'd2000)), 32'hEE);
        host_read(11'd2000, 8'h00, "rd2000");

        // Asynchronous reset in the middle of a host write
        lcd_x = 8'd3;
        lcd_y = 4'd0;
        for (int i = 0; i < 4; i++) tick();
        wr_addr  = 11'd5;
        wr_data  = 8'h99;
        wr_valid = 1'b1;
        begin
            bit seen = 0;
            for (int i = 0; i < 20 && !seen; i++) begin
                tick();
                if (wr_ready) seen = 1;
            end
            check("abort_ack_seen", 32'(seen), 1);
        end
        reset = 1'b0;
        #1;
        check("abort_drop", {30'd0, wr_ready, ram_we}, 0);
        wr_valid = 1'b0;
        tick();
        check("abort_pix", 32'(lcd_pixels), 0);
        check("abort_mem", 32'(model(11'd5)), 32'h05);
        reset = 1'b1;
        tick();
        check("abort_idle_fetch", 32'(ram_addr), 3);
        tick();
        tick();
        check("abort_pix_refetch", 32'(lcd_pixels), 32'h03);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
